// File: rtl/aes_disp_pkg.sv
// Shared types and constants for the AES result-block byte scanner.
// Used by the scanner FSM and by its double-dabble step.
package aes_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } state_t;

  localparam int NUM_BYTES  = 16;
  localparam int BCD_W      = 12;
  localparam int BIN_W      = 8;
  localparam int CONV_ITERS = 8;
  localparam int SHIFT_W    = BCD_W + BIN_W;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration on the {bcd12, bin8} shift register.
// Every BCD nibble >= 5 gets +3, then the whole word shifts left by one.
module bcd_dabble_step
  import aes_disp_pkg::*;
(
  input  logic [SHIFT_W-1:0] din_i,
  output logic [SHIFT_W-1:0] dout_o
);

  logic [SHIFT_W-1:0] adj;

  assign adj[BIN_W-1:0] = din_i[BIN_W-1:0];

  generate
    for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_nib
      assign adj[BIN_W+4*gi +: 4] = (din_i[BIN_W+4*gi +: 4] >= 4'd5) ?
                                    din_i[BIN_W+4*gi +: 4] + 4'd3 :
                                    din_i[BIN_W+4*gi +: 4];
    end
  endgenerate

  assign dout_o = adj << 1;

endmodule

// File: rtl/aes_byte_scanner.sv
// Latches a 128-bit AES block and shows each byte, MSB byte first, as a
// 3-digit BCD value for a programmable dwell time.
module aes_byte_scanner
  import aes_disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int HOLD_W      = $clog2(HOLD_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  input  logic [127:0] blk_data,
  output logic         blk_ready,
  input  logic         pause,
  input  logic         loop,
  output logic [3:0]   byte_idx,
  output logic [11:0]  bcd,
  output logic         bcd_valid,
  output logic         scan_done
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t               state_q, state_d;
  logic [127:0]         block_q, block_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [2:0]           iter_q, iter_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [3:0]           idx_q, idx_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 bcd_valid_q, bcd_valid_d;
  logic                 scan_done_q, scan_done_d;

  logic [SHIFT_W-1:0]   step_out;
  logic [BIN_W-1:0]     byte_arr [NUM_BYTES];
  logic [3:0]           next_idx;
  logic                 accept;

  // byte_arr[0] is the most significant byte of the latched block
  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
      assign byte_arr[gi] = block_q[127 - 8*gi -: 8];
    end
  endgenerate

  bcd_dabble_step u_step (
    .din_i  (shift_q),
    .dout_o (step_out)
  );

  assign blk_ready = (state_q != CONV);
  assign accept    = blk_valid && blk_ready;
  assign next_idx  = idx_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    block_d     = block_q;
    shift_d     = shift_q;
    iter_d      = iter_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    bcd_d       = bcd_q;
    bcd_valid_d = bcd_valid_q;
    scan_done_d = 1'b0;

    // A new block wins over any dwell expiry happening on the same edge
    if (accept) begin
      block_d     = blk_data;
      idx_d       = 4'd0;
      shift_d     = {{BCD_W{1'b0}}, blk_data[127:120]};
      iter_d      = 3'd0;
      bcd_valid_d = 1'b0;
      state_d     = CONV;
    end else begin
      case (state_q)
        CONV: begin
          shift_d = step_out;
          if (iter_q == 3'(CONV_ITERS - 1)) begin
            bcd_d       = step_out[SHIFT_W-1:BIN_W];
            bcd_valid_d = 1'b1;
            hold_d      = '0;
            state_d     = SHOW;
          end else begin
            iter_d = iter_q + 3'd1;
          end
        end
        SHOW: begin
          if (!pause) begin
            if (hold_q == HOLD_LAST) begin
              bcd_valid_d = 1'b0;
              if (idx_q != 4'(NUM_BYTES - 1)) begin
                idx_d   = next_idx;
                shift_d = {{BCD_W{1'b0}}, byte_arr[next_idx]};
                iter_d  = 3'd0;
                state_d = CONV;
              end else begin
                scan_done_d = 1'b1;
                if (loop) begin
                  idx_d   = 4'd0;
                  shift_d = {{BCD_W{1'b0}}, byte_arr[0]};
                  iter_d  = 3'd0;
                  state_d = CONV;
                end else begin
                  state_d = IDLE;
                end
              end
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      block_q     <= '0;
      shift_q     <= '0;
      iter_q      <= '0;
      hold_q      <= '0;
      idx_q       <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      shift_q     <= shift_d;
      iter_q      <= iter_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign byte_idx  = idx_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_aes_byte_scanner.sv
// Scoreboard bench for aes_byte_scanner with HOLD_CYCLES = 4: stimulus queues
// expected byte/scan_done events, a negedge monitor pops and compares them.
module tb_aes_byte_scanner;

  localparam int H = 4;
  localparam int PER = H + 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         blk_ready;
  logic         pause;
  logic         loop;
  logic [3:0]   byte_idx;
  logic [11:0]  bcd;
  logic         bcd_valid;
  logic         scan_done;

  aes_byte_scanner #(.HOLD_CYCLES(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_ready (blk_ready),
    .pause     (pause),
    .loop      (loop),
    .byte_idx  (byte_idx),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          done;
    int          idx;
    logic [11:0] bcd;
    int          cyc;
    int          dwell;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  localparam logic [127:0] BLK1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [11:0] exp_bcd [2][16] = '{
    '{12'h000, 12'h017, 12'h034, 12'h051, 12'h068, 12'h085, 12'h102, 12'h119,
      12'h136, 12'h153, 12'h170, 12'h187, 12'h204, 12'h221, 12'h238, 12'h255},
    '{12'h105, 12'h196, 12'h224, 12'h216, 12'h106, 12'h123, 12'h004, 12'h048,
      12'h216, 12'h205, 12'h183, 12'h128, 12'h112, 12'h180, 12'h197, 12'h090}
  };

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cyc %0d", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic push_byte(input int idx, input logic [11:0] b, input int c, input int dw);
    ev_t e;
    e.done = 1'b0; e.idx = idx; e.bcd = b; e.cyc = c; e.dwell = dw;
    sb.push_back(e);
  endtask

  task automatic push_done(input int c);
    ev_t e;
    e.done = 1'b1; e.idx = 15; e.bcd = 12'h000; e.cyc = c; e.dwell = 0;
    sb.push_back(e);
  endtask

  task automatic accept(input logic [127:0] d, output int a);
    chk("ready_before_accept", 32'(blk_ready), 32'd1);
    blk_data  = d;
    blk_valid = 1'b1;
    step();
    a = cyc;
    blk_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d events still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: checks each bcd_valid rise, its dwell length, and each scan_done
  initial begin
    ev_t e;
    bit  prev_v = 1'b0;
    bit  tracking = 1'b0;
    int  dwell_cnt = 0;
    int  dwell_exp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v   = 1'b0;
        tracking = 1'b0;
      end else begin
        if (bcd_valid && !prev_v) begin
          if (sb.size() == 0 || sb[0].done) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got idx %0d bcd 0x%03h at cyc %0d, expected %s",
                     byte_idx, bcd, cyc, (sb.size() == 0) ? "no event" : "scan_done");
            if (sb.size() != 0) void'(sb.pop_front());
            tracking = 1'b0;
          end else begin
            e = sb.pop_front();
            chk("byte_idx", 32'(byte_idx), 32'(e.idx));
            chk("byte_bcd", 32'(bcd), 32'(e.bcd));
            chk("byte_cyc", 32'(cyc), 32'(e.cyc));
            tracking  = 1'b1;
            dwell_exp = e.dwell;
          end
          dwell_cnt = 1;
        end else if (bcd_valid) begin
          dwell_cnt++;
        end
        if (!bcd_valid && prev_v && tracking) begin
          chk("dwell_len", 32'(dwell_cnt), 32'(dwell_exp));
          tracking = 1'b0;
        end
        if (scan_done) begin
          if (sb.size() == 0 || !sb[0].done) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_scan_done: got pulse at cyc %0d, expected %s",
                     cyc, (sb.size() == 0) ? "no event" : "byte event");
            if (sb.size() != 0) void'(sb.pop_front());
          end else begin
            e = sb.pop_front();
            chk("scan_done_cyc", 32'(cyc), 32'(e.cyc));
          end
        end
        prev_v = bcd_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2;
    rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; pause = 1'b0; loop = 1'b0;
    step(); step(); step();
    chk("rst_blk_ready", 32'(blk_ready), 32'd1);
    chk("rst_byte_idx", 32'(byte_idx), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_bcd_valid", 32'(bcd_valid), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    rst_n = 1'b1;
    step(); step();

    // Plain scan, loop=0, with blk_ready tracked every cycle
    accept(BLK1, a);
    for (int k = 0; k < 16; k++) push_byte(k, exp_bcd[0][k], a + 8 + PER*k, H);
    push_done(a + 16*PER);
    for (int i = 0; i <= 16*PER; i++) begin
      int rel;
      rel = cyc - a;
      chk("blk_ready_scan", 32'(blk_ready), 32'((rel >= 16*PER) || (rel % PER >= 8)));
      step();
    end
    drain(20);
    chk("idle_byte_idx", 32'(byte_idx), 32'd15);
    chk("idle_bcd", 32'(bcd), 32'h255);
    chk("idle_bcd_valid", 32'(bcd_valid), 32'd0);
    chk("idle_scan_done", 32'(scan_done), 32'd0);
    step(); step();

    // Pause 10 cycles in byte 3's dwell, then pause during byte 5's CONV
    accept(BLK2, a);
    for (int k = 0; k < 16; k++)
      push_byte(k, exp_bcd[1][k], a + 8 + PER*k + ((k > 3) ? 10 : 0), (k == 3) ? H + 10 : H);
    push_done(a + 16*PER + 10);
    wait_cyc(a + 45);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) step();
    pause = 1'b0;
    wait_cyc(a + 72);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ready_conv_paused", 32'(blk_ready), 32'd0);
      step();
    end
    pause = 1'b0;
    drain(300);
    step(); step();

    // loop=1: wrap to byte 0, then restart with a new block on byte 15's expiry
    loop = 1'b1;
    accept(BLK2, a);
    for (int k = 0; k < 16; k++) push_byte(k, exp_bcd[1][k], a + 8 + PER*k, H);
    push_done(a + 16*PER);
    for (int k = 0; k < 16; k++) push_byte(k, exp_bcd[1][k], a + 16*PER + 8 + PER*k, H);
    wait_cyc(a + 16*PER + 1);
    chk("wrap_byte_idx", 32'(byte_idx), 32'd0);
    chk("wrap_ready_conv", 32'(blk_ready), 32'd0);
    chk("wrap_bcd_valid", 32'(bcd_valid), 32'd0);
    wait_cyc(a + 32*PER - 1);
    accept(BLK1, a2);
    chk("restart_edge", 32'(a2), 32'(a + 32*PER));
    loop = 1'b0;
    for (int k = 0; k < 16; k++) push_byte(k, exp_bcd[0][k], a2 + 8 + PER*k, H);
    push_done(a2 + 16*PER);
    drain(300);
    step(); step();

    // Reset during byte 5's dwell, then a clean restart
    accept(BLK1, a);
    for (int k = 0; k < 6; k++) push_byte(k, exp_bcd[0][k], a + 8 + PER*k, H);
    wait_cyc(a + 8 + 5*PER + 1);
    chk("pre_rst_byte_idx", 32'(byte_idx), 32'd5);
    chk("pre_rst_bcd_valid", 32'(bcd_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_blk_ready", 32'(blk_ready), 32'd1);
    chk("async_rst_byte_idx", 32'(byte_idx), 32'd0);
    chk("async_rst_bcd", 32'(bcd), 32'd0);
    chk("async_rst_bcd_valid", 32'(bcd_valid), 32'd0);
    chk("async_rst_scan_done", 32'(scan_done), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) step();
    drain(1);
    accept(BLK2, a);
    for (int k = 0; k < 16; k++) push_byte(k, exp_bcd[1][k], a + 8 + PER*k, H);
    push_done(a + 16*PER);
    drain(300);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
